// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_pkg
//  Purpose  : Shared widths, constants and fetch FSM type for the 5-stage
//             pipeline front end.
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int PC_W  = 32;
  localparam int INS_W = 32;

  // All-zero encoding is the pipeline NOP and the bubble instruction.
  localparam logic [INS_W-1:0] NOP_INS = 32'h0;

  localparam logic [INS_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam int               DEFAULT_MEM_WORDS = 10240;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Sequential word address with wrap at the last memory word.
  function automatic logic [PC_W-1:0] pc_next_seq(
    input logic [PC_W-1:0] pc,
    input logic [PC_W-1:0] last_pc
  );
    return (pc == last_pc) ? '0 : pc + PC_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : ifid_reg
//  Purpose  : IF/ID pipeline register. bubble clears it to a NOP, load
//             captures a fetched instruction, otherwise it holds.
//  Revision : 1.0 - initial release
// ============================================================================
module ifid_reg
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bubble,
  input  logic [INS_W-1:0] ins,
  input  logic [PC_W-1:0]  pc_plus1,
  output logic [INS_W-1:0] ifid_ins,
  output logic [PC_W-1:0]  ifid_pc_plus1,
  output logic             ifid_valid
);

  // Bubble wins over load so the owner never has to mask both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_ins      <= NOP_INS;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
    end else if (bubble) begin
      ifid_ins      <= NOP_INS;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
    end else if (load) begin
      ifid_ins      <= ins;
      ifid_pc_plus1 <= pc_plus1;
      ifid_valid    <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_stage
//  Purpose  : Instruction-fetch stage. Owns the PC, drives the word-indexed
//             instruction memory address, and fills the IF/ID register with
//             stall / flush / redirect handling and a halt sentinel.
//  Options  : IF_FETCH_PERF_EN adds fetch and bubble event counters.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0]  RESET_PC  = 32'd0,
  parameter int               MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter logic [INS_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  pc_out,
  input  logic [INS_W-1:0] ins_in,
  output logic [INS_W-1:0] ifid_ins,
  output logic [PC_W-1:0]  ifid_pc_plus1,
  output logic             ifid_valid,
  output logic             halted
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_bubble_cnt
`endif
);

  localparam logic [1:0] ST_BOOT = 2'(BOOT);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_HALT = 2'(HALT);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(MEM_WORDS - 1);

  logic [1:0]      state;
  logic [1:0]      state_d;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] next_seq;
  logic            load;
  logic            bubble;

  assign next_seq = pc_next_seq(pc, LAST_PC);
  assign pc_out   = pc;
  assign halted   = (state == ST_HALT);

  // Next-state, next-PC and IF/ID control, in the RUN priority order.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    load    = 1'b0;
    bubble  = 1'b0;
    case (state)
      ST_BOOT: begin
        // One settling cycle after reset; all requests are ignored.
        bubble  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          bubble = 1'b1;
          pc_d   = redirect_pc;
        end else if (flush) begin
          bubble = 1'b1;
          if (!stall) begin
            pc_d = next_seq;
          end
        end else if (stall) begin
          // Hold PC and IF/ID.
        end else if (ins_in == HALT_WORD) begin
          bubble  = 1'b1;
          state_d = ST_HALT;
        end else begin
          load = 1'b1;
          pc_d = next_seq;
        end
      end
      ST_HALT: begin
        // Only a redirect leaves HALT; the redirect edge itself is a bubble.
        bubble = 1'b1;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_RUN;
        end
      end
      default: begin
        bubble  = 1'b1;
        state_d = ST_BOOT;
      end
    endcase
  end

  // PC and FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= ST_BOOT;
    end else begin
      pc    <= pc_d;
      state <= state_d;
    end
  end

  ifid_reg u_ifid_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .bubble        (bubble),
    .ins           (ins_in),
    .pc_plus1      (next_seq),
    .ifid_ins      (ifid_ins),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid)
  );

`ifdef IF_FETCH_PERF_EN
  logic fetch_evt;
  logic bubble_evt;

  // Bubbles are counted only when RUN actively loads an invalid entry.
  assign fetch_evt  = (state == ST_RUN) && load;
  assign bubble_evt = (state == ST_RUN) && bubble;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (fetch_evt) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (bubble_evt) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_stage
//  Purpose  : Self-checking bench for if_fetch_stage: directed vector table,
//             async-reset / BOOT sequence, and randomized run against a
//             behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  localparam int          MW = 10240;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] ins_in;
  logic [31:0] ifid_ins;
  logic [31:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic        halted;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  logic [31:0] mem [0:MW-1];

  assign ins_in = (pc_out < 32'(MW)) ? mem[pc_out[13:0]] : 32'h0;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC  (32'd0),
    .MEM_WORDS (MW),
    .HALT_WORD (HW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_out         (pc_out),
    .ins_in         (ins_in),
    .ifid_ins       (ifid_ins),
    .ifid_pc_plus1  (ifid_pc_plus1),
    .ifid_valid     (ifid_valid),
    .halted         (halted)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_pc;
  logic [31:0] m_ins;
  int unsigned m_pp1;
  bit          m_valid;
  bit          m_halted;
  bit          m_boot;
  int unsigned m_fetches;
  int unsigned m_bubbles;

  task automatic model_reset();
    m_pc = 0; m_ins = 32'h0; m_pp1 = 0; m_valid = 0;
    m_halted = 0; m_boot = 1; m_fetches = 0; m_bubbles = 0;
  endtask

  task automatic model_bubble();
    m_ins = 32'h0; m_pp1 = 0; m_valid = 0; m_bubbles++;
  endtask

  task automatic model_edge(input bit s, input bit f, input bit rv, input logic [31:0] rpc);
    int unsigned seq;
    logic [31:0] word;
    seq  = (m_pc + 1) % MW;
    word = mem[m_pc];
    if (m_boot) begin
      m_boot = 0;
    end else if (m_halted) begin
      if (rv) begin
        m_pc = rpc; m_halted = 0;
      end
    end else if (rv) begin
      m_pc = rpc; model_bubble();
    end else if (f) begin
      model_bubble();
      if (!s) m_pc = seq;
    end else if (s) begin
      // nothing moves
    end else if (word == HW) begin
      model_bubble(); m_halted = 1;
    end else begin
      m_ins = word; m_pp1 = seq; m_valid = 1; m_pc = seq; m_fetches++;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    pc_out,        m_pc);
    chk({tag, ".ins"},   ifid_ins,      m_ins);
    chk({tag, ".pp1"},   ifid_pc_plus1, m_pp1);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
    chk({tag, ".halt"},  {31'd0, halted},     {31'd0, m_halted});
`ifdef IF_FETCH_PERF_EN
    chk({tag, ".pfetch"},  perf_fetch_cnt,  m_fetches);
    chk({tag, ".pbubble"}, perf_bubble_cnt, m_bubbles);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".pc"},    pc_out,        32'd0);
    chk({tag, ".ins"},   ifid_ins,      32'd0);
    chk({tag, ".pp1"},   ifid_pc_plus1, 32'd0);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, 32'd0);
    chk({tag, ".halt"},  {31'd0, halted},     32'd0);
  endtask

  // Drive one cycle of inputs, take the edge, sample 1 time unit later.
  task automatic step(input bit s, input bit f, input bit rv, input logic [31:0] rpc);
    stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    model_edge(s, f, rv, rpc);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          s, f, rv;
    logic [31:0] rpc;
    logic [31:0] pc, ins, pp1;
    bit          v, h;
  } vec_t;

  vec_t vt[$];

  function automatic void addv(input bit s, input bit f, input bit rv, input logic [31:0] rpc,
                               input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] pp1, input bit v, input bit h);
    vec_t r;
    r.s = s; r.f = f; r.rv = rv; r.rpc = rpc;
    r.pc = pc; r.ins = ins; r.pp1 = pp1; r.v = v; r.h = h;
    vt.push_back(r);
  endfunction

  initial begin
    for (int i = 0; i < MW; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h0022_1820;
    mem[1] = 32'h8C01_0004;
    mem[2] = 32'h0000_0000;
    mem[7] = HW;

    rst = 1'b1; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    model_reset();
    rst = 1'b0;

    //    s  f  rv rpc     pc      ins            pp1  v  h
    addv(0, 0, 0, 0,      0,      32'h0,         0,   0, 0); // BOOT edge
    addv(0, 0, 0, 0,      1,      32'h0022_1820, 1,   1, 0);
    addv(0, 0, 0, 0,      2,      32'h8C01_0004, 2,   1, 0);
    addv(0, 0, 0, 0,      3,      32'h0,         3,   1, 0);
    addv(0, 0, 0, 0,      4,      32'h1000_0003, 4,   1, 0);
    addv(0, 0, 0, 0,      5,      32'h1000_0004, 5,   1, 0);
    for (int i = 0; i < 3; i++)
      addv(1, 0, 0, 0,    5,      32'h1000_0004, 5,   1, 0); // stall hold
    addv(0, 0, 0, 0,      6,      32'h1000_0005, 6,   1, 0);
    addv(1, 0, 1, 40,     40,     32'h0,         0,   0, 0); // redirect beats stall
    addv(0, 0, 0, 0,      41,     32'h1000_0028, 41,  1, 0);
    addv(0, 1, 0, 0,      42,     32'h0,         0,   0, 0); // flush advances
    addv(1, 1, 0, 0,      42,     32'h0,         0,   0, 0); // flush+stall holds pc
    addv(0, 0, 0, 0,      43,     32'h1000_002A, 43,  1, 0);
    addv(0, 0, 1, MW-1,   MW-1,   32'h0,         0,   0, 0);
    addv(0, 0, 0, 0,      0,      32'h1000_27FF, 0,   1, 0); // wrap
    addv(0, 0, 1, 7,      7,      32'h0,         0,   0, 0);
    addv(0, 0, 0, 0,      7,      32'h0,         0,   0, 1); // halt word
    for (int i = 0; i < 10; i++)
      addv(bit'((i / 2) % 2), bit'(i % 2), 0, 0, 7, 32'h0, 0, 0, 1);
    addv(0, 0, 1, 3,      3,      32'h0,         0,   0, 0); // leave HALT
    addv(0, 0, 0, 0,      4,      32'h1000_0003, 4,   1, 0);
    addv(0, 0, 1, 20,     20,     32'h0,         0,   0, 0);
    addv(1, 0, 0, 0,      20,     32'h0,         0,   0, 0);

    foreach (vt[k]) begin
      step(vt[k].s, vt[k].f, vt[k].rv, vt[k].rpc);
      chk($sformatf("vec%0d.pc", k),    pc_out,        vt[k].pc);
      chk($sformatf("vec%0d.ins", k),   ifid_ins,      vt[k].ins);
      chk($sformatf("vec%0d.pp1", k),   ifid_pc_plus1, vt[k].pp1);
      chk($sformatf("vec%0d.valid", k), {31'd0, ifid_valid}, {31'd0, vt[k].v});
      chk($sformatf("vec%0d.halt", k),  {31'd0, halted},     {31'd0, vt[k].h});
    end

    // Async reset mid-stall at pc=20, checked before any clock edge.
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // BOOT repeats and ignores every request.
    step(1, 1, 1, 99);
    check_model("boot2");
    chk("boot2.pc_fixed", pc_out, 32'd0);
    step(0, 0, 0, 0);
    chk("boot2.first_ins", ifid_ins, 32'h0022_1820);
    chk("boot2.first_pp1", ifid_pc_plus1, 32'd1);
    chk("boot2.first_valid", {31'd0, ifid_valid}, 32'd1);

    // Randomized run against the model.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit          s, f, rv;
      logic [31:0] rpc;
      int unsigned sel;
      s   = ($urandom % 4) == 0;
      f   = ($urandom % 10) == 0;
      rv  = ($urandom % 20) == 0;
      sel = $urandom % 8;
      case (sel)
        0:       rpc = 32'd7;
        1:       rpc = 32'(MW - 1);
        2:       rpc = 32'(MW - 2);
        default: rpc = 32'($urandom % MW);
      endcase
      step(s, f, rv, rpc);
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
